// File: rtl/dds_pkg.sv
// Shared definitions for the DDS ROM reader: FSM states, ROM latency and DA midscale helpers.
package dds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dds_state_e;

    // Read latency of the external waveform ROM, with or without its output register.
    function automatic int dds_rom_latency(input int out_reg);
        return 1 + out_reg;
    endfunction

    // Offset-binary zero code for a DA of the given width.
    function automatic int unsigned dds_midscale(input int dw);
        return 32'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/dds_vld_pipe.sv
// Valid-bit delay line that follows issued ROM addresses through the ROM read latency.
module dds_vld_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    output logic vld_o,
    output logic empty_o
);

    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign vld_o   = vld_q[DEPTH-1];
    assign empty_o = ~|vld_q;

endmodule

// File: rtl/dds_rom_reader.sv
// Phase-accumulator DDS front end: walks a waveform ROM and forwards the samples to a DA.
module dds_rom_reader
    import dds_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 10,
    parameter int PHASE_WIDTH = 32,
    parameter int OUT_REG     = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   one_shot,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic [ADDR_WIDTH-1:0]  phase_ofs,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_rd_data,
    output logic [DATA_WIDTH-1:0]  da_data,
    output logic                   da_valid,
    output logic                   busy
);

    localparam int L = dds_rom_latency(OUT_REG);
    localparam logic [DATA_WIDTH-1:0] MIDSCALE = DATA_WIDTH'(dds_midscale(DATA_WIDTH));

    dds_state_e               state_q, state_d;
    logic [PHASE_WIDTH-1:0]   acc_q, acc_d;
    logic [PHASE_WIDTH-1:0]   fw_q, fw_d;
    logic [ADDR_WIDTH-1:0]    ofs_q, ofs_d;
    logic                     os_q, os_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     addr_vld_q, addr_vld_d;
    logic [DATA_WIDTH-1:0]    da_q, da_d;
    logic                     da_vld_q, da_vld_d;
    logic [PHASE_WIDTH:0]     sum;
    logic                     pipe_vld;
    logic                     pipe_empty;

    // The extra MSB is the wrap carry that ends a one-shot pass.
    assign sum = {1'b0, acc_q} + {1'b0, fw_q};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        fw_d       = fw_q;
        ofs_d      = ofs_q;
        os_d       = os_q;
        addr_d     = addr_q;
        addr_vld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    fw_d    = freq_word;
                    ofs_d   = phase_ofs;
                    os_d    = one_shot;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d     = acc_q[PHASE_WIDTH-1 -: ADDR_WIDTH] + ofs_q;
                    addr_vld_d = 1'b1;
                    acc_d      = sum[PHASE_WIDTH-1:0];
                    if (os_q && sum[PHASE_WIDTH]) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Wait until every issued address has come back as a DA sample.
                if (pipe_empty && !addr_vld_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign da_vld_d = pipe_vld;
    assign da_d     = pipe_vld ? rom_rd_data : MIDSCALE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            fw_q       <= '0;
            ofs_q      <= '0;
            os_q       <= 1'b0;
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            da_q       <= MIDSCALE;
            da_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fw_q       <= fw_d;
            ofs_q      <= ofs_d;
            os_q       <= os_d;
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
            da_q       <= da_d;
            da_vld_q   <= da_vld_d;
        end
    end

    dds_vld_pipe #(
        .DEPTH(L)
    ) u_vld_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (addr_vld_q),
        .vld_o  (pipe_vld),
        .empty_o(pipe_empty)
    );

    assign rom_addr = addr_q;
    assign da_data  = da_q;
    assign da_valid = da_vld_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dds_rom_reader.sv
// Scoreboard bench: two readers (OUT_REG=0 and 1) share stimulus, each behind its own ROM model.
module tb_dds_rom_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, one_shot;
    logic [31:0] freq_word;
    logic [9:0]  phase_ofs;
    logic [9:0]  rom_addr0, rom_addr1, rom_rd0, rom_rd1, rom1_a;
    logic [9:0]  da_data0, da_data1;
    logic        da_valid0, da_valid1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int addr_cyc = 0;
    bit lat_arm0 = 0;
    bit lat_arm1 = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents are data = address; OUT_REG=1 adds an output register.
    always @(posedge clk) begin
        rom_rd0 <= rom_addr0;
        rom1_a  <= rom_addr1;
        rom_rd1 <= rom1_a;
    end

    dds_rom_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(10), .PHASE_WIDTH(32), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .one_shot(one_shot),
        .freq_word(freq_word), .phase_ofs(phase_ofs), .rom_addr(rom_addr0),
        .rom_rd_data(rom_rd0), .da_data(da_data0), .da_valid(da_valid0), .busy(busy0));

    dds_rom_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(10), .PHASE_WIDTH(32), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .one_shot(one_shot),
        .freq_word(freq_word), .phase_ofs(phase_ofs), .rom_addr(rom_addr1),
        .rom_rd_data(rom_rd1), .da_data(da_data1), .da_valid(da_valid1), .busy(busy1));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input int v);
        q0.push_back(v);
        q1.push_back(v);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 40) begin
            tick;
            n++;
        end
        chk("idle_within_budget", int'(n < 40), 1);
        repeat (3) tick;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_q0_empty"}, q0.size(), 0);
        chk({nm, "_q1_empty"}, q1.size(), 0);
        chk({nm, "_da_valid0"}, da_valid0, 0);
        chk({nm, "_da_valid1"}, da_valid1, 0);
        chk({nm, "_da_data0"}, da_data0, 512);
        chk({nm, "_da_data1"}, da_data1, 512);
        chk({nm, "_busy0"}, busy0, 0);
        chk({nm, "_busy1"}, busy1, 0);
    endtask

    // Monitor: every presented sample must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && da_valid0) begin
            if (lat_arm0) begin
                chk("latency0", cyc - addr_cyc, 2);
                lat_arm0 = 0;
            end
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_sample0: got %0d expected none", da_data0);
            end else begin
                chk("da_data0", da_data0, q0.pop_front());
            end
        end
        if (rst_n && da_valid1) begin
            if (lat_arm1) begin
                chk("latency1", cyc - addr_cyc, 3);
                lat_arm1 = 0;
            end
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_sample1: got %0d expected none", da_data1);
            end else begin
                chk("da_data1", da_data1, q1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; one_shot = 0;
        freq_word = '0; phase_ofs = '0;
        repeat (2) tick;
        chk("rst_addr0", rom_addr0, 0);
        chk("rst_addr1", rom_addr1, 0);
        chk_quiet("reset");
        rst_n = 1'b1;
        tick;

        // Basic run, both latencies.
        freq_word = 32'h0040_0000; phase_ofs = 10'd0; one_shot = 0;
        start = 1; tick; start = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk("basic_addr0", rom_addr0, k);
            chk("basic_addr1", rom_addr1, k);
            push2(k);
            if (k == 0) begin
                addr_cyc = cyc;
                lat_arm0 = 1;
                lat_arm1 = 1;
            end
        end
        stop = 1; tick; stop = 0;
        chk("basic_addr_hold", rom_addr0, 7);
        wait_idle;
        chk_quiet("basic_end");

        // One-shot pass that wraps the accumulator after two addresses.
        freq_word = 32'h8000_0000; phase_ofs = 10'd1023; one_shot = 1;
        start = 1; tick; start = 0; one_shot = 0;
        tick; chk("os_addr_a", rom_addr0, 1023); push2(1023);
        tick; chk("os_addr_b", rom_addr0, 511);  push2(511);
        tick; chk("os_addr_hold", rom_addr1, 511);
        wait_idle;
        chk_quiet("oneshot_end");

        // Stop and drain; mid-run input changes and a start pulse must be ignored.
        freq_word = 32'h0040_0000; phase_ofs = 10'd0;
        start = 1; tick; start = 0;
        freq_word = 32'h0080_0000; phase_ofs = 10'd100;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("stop_addr0", rom_addr0, k);
            chk("stop_addr1", rom_addr1, k);
            push2(k);
            start = (k == 2);
        end
        start = 0;
        stop = 1; tick; stop = 0;
        chk("stop_addr_hold", rom_addr1, 5);
        wait_idle;
        chk_quiet("stop_end");

        // Start and stop together in IDLE: nothing happens.
        start = 1; stop = 1; tick; start = 0; stop = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("ss_busy0", busy0, 0);
            chk("ss_busy1", busy1, 0);
            chk("ss_valid1", da_valid1, 0);
        end

        // Zero frequency word: constant address, continuous samples, one_shot never fires.
        freq_word = 32'd0; phase_ofs = 10'd42; one_shot = 1;
        start = 1; tick; start = 0; one_shot = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            chk("fz_addr0", rom_addr0, 42);
            push2(42);
            if (k >= 2) chk("fz_valid0", da_valid0, 1);
            if (k >= 3) chk("fz_valid1", da_valid1, 1);
        end
        chk("fz_busy", busy1, 1);
        stop = 1; tick; stop = 0;
        wait_idle;
        chk_quiet("fz_end");

        // Asynchronous reset in the middle of a run.
        freq_word = 32'h0040_0000; phase_ofs = 10'd0;
        start = 1; tick; start = 0;
        for (int k = 0; k <= 300; k++) begin
            tick;
            chk("rr_addr0", rom_addr0, k);
            chk("rr_addr1", rom_addr1, k);
            push2(k);
        end
        rst_n = 1'b0;
        #1;
        chk("rr_addr0_zero", rom_addr0, 0);
        chk("rr_addr1_zero", rom_addr1, 0);
        q0.delete();
        q1.delete();
        chk_quiet("rr_async");
        repeat (3) tick;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rr_idle_busy0", busy0, 0);
            chk("rr_idle_valid0", da_valid0, 0);
            chk("rr_idle_addr1", rom_addr1, 0);
        end

        // A fresh start runs again with newly latched values.
        phase_ofs = 10'd7;
        start = 1; tick; start = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("rs_addr0", rom_addr0, 7 + k);
            chk("rs_addr1", rom_addr1, 7 + k);
            push2(7 + k);
        end
        stop = 1; tick; stop = 0;
        wait_idle;
        chk_quiet("restart_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
